skew_recirc_buffer: RTL and testbench

SKEW_RECIRC_BUFFER -- requirements
Module: skew_recirc_buffer

---
 rtl/skew_recirc_buffer.sv | 137 +++++++++++++
 tb/tb_skew_recirc_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/skew_recirc_buffer.sv
// rtl/skew_recirc_buffer.sv - per-lane recirculating word buffer with step-qualified output path
// Optional feature macro SKEW_RECIRC_SKEW_EN: lane k gets k extra output stages and a DRAIN phase.
module skew_recirc_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 9,
   parameter int LANES      = 4,
   parameter int PASS_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        start,
   input  logic [PASS_W-1:0]           num_passes,
   input  logic                        in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] data_in,
   input  logic                        step,
   output logic [LANES*DATA_WIDTH-1:0] data_out,
   output logic [LANES-1:0]            out_valid,
   output logic                        busy,
   output logic                        done
);
`ifdef SKEW_RECIRC_SKEW_EN
   localparam bit SKEW_EN = 1'b1;
`else
   localparam bit SKEW_EN = 1'b0;
`endif
   localparam int CW  = $clog2(DEPTH);
   localparam int DCW = $clog2(LANES) + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     word_cnt;
   logic [PASS_W-1:0] pass_cnt, pass_tgt;
   logic [DCW-1:0]    drain_cnt;
   logic              word_last, pass_last, load_en, run_en, adv_en;

   assign word_last = (word_cnt == CW'(DEPTH - 1));
   assign pass_last = (pass_cnt == pass_tgt - 1'b1);
   assign load_en   = (state == S_LOAD) && in_valid;
   assign run_en    = (state == S_RUN) && step;
   assign adv_en    = step && ((state == S_RUN) || (state == S_DRAIN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state <= S_IDLE;
      else if (clear) state <= S_IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_LOAD;
         S_LOAD:  if (in_valid && word_last) state_nx = S_RUN;
         S_RUN:   if (step && word_last && pass_last)
                     state_nx = (SKEW_EN && LANES > 1) ? S_DRAIN : S_DONE;
         S_DRAIN: if (step && drain_cnt == DCW'(LANES - 2)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clear) begin
         word_cnt  <= '0;
         pass_cnt  <= '0;
         pass_tgt  <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               word_cnt <= '0;
               pass_tgt <= (num_passes == '0) ? PASS_W'(1) : num_passes;
            end
            S_LOAD: if (in_valid) begin
               if (word_last) begin
                  word_cnt <= '0;
                  pass_cnt <= '0;
               end else begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
            S_RUN: if (step) begin
               drain_cnt <= '0;
               if (word_last) begin
                  word_cnt <= '0;
                  pass_cnt <= pass_cnt + 1'b1;
               end else begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
            S_DRAIN: if (step) drain_cnt <= drain_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int NST = SKEW_EN ? k + 1 : 1;
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] sd  [NST];
      logic [NST-1:0]        sv;

      // Slot DEPTH-1 always holds the oldest word; RUN rotates it back into slot 0.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n || clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end else if (load_en || run_en) begin
            mem[0] <= load_en ? data_in[k*DATA_WIDTH +: DATA_WIDTH] : mem[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n || clear) begin
            for (int j = 0; j < NST; j++) sd[j] <= '0;
            sv <= '0;
         end else if (adv_en) begin
            sd[0] <= run_en ? mem[DEPTH-1] : '0;
            sv[0] <= run_en;
            for (int j = 1; j < NST; j++) begin
               sd[j] <= sd[j-1];
               sv[j] <= sv[j-1];
            end
         end
      end

      assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = sd[NST-1];
      assign out_valid[k] = sv[NST-1];
   end

endmodule

// File: tb/tb_skew_recirc_buffer.sv
// tb/tb_skew_recirc_buffer.sv - randomized scoreboard bench for skew_recirc_buffer
// Follows SKEW_RECIRC_SKEW_EN to choose skewed or aligned expectations.
module tb_skew_recirc_buffer;
   localparam int DW = 8, DEPTH = 4, LANES = 2, PW = 8, IW = LANES * DW;
`ifdef SKEW_RECIRC_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif

   logic           clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
   logic           in_valid = 1'b0, step = 1'b0;
   logic [PW-1:0]  num_passes = '0;
   logic [IW-1:0]  data_in = '0, data_out;
   logic [LANES-1:0] out_valid;
   logic           busy, done;

   skew_recirc_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(LANES), .PASS_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .num_passes(num_passes),
      .in_valid(in_valid), .data_in(data_in), .step(step), .data_out(data_out),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             done;
      logic [LANES-1:0] valid;
      logic [IW-1:0]    data;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          last_exp = '0;
   int            n_checks = 0, n_fail = 0;
   logic          run_phase = 1'b0, fire = 1'b0, hold = 1'b0;
   logic [DW-1:0] words [LANES][DEPTH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Emitted stream per lane is the load order repeated; lane k sees word i at step i+1+k*SKEW.
   function automatic exp_t model(input int s, input int n, input int total);
      exp_t e;
      int   i;
      e = '0;
      for (int k = 0; k < LANES; k++) begin
         i = s - 1 - SKEW * k;
         if (i >= 0 && i < n) begin
            e.valid[k] = 1'b1;
            e.data[k*DW +: DW] = words[k][i % DEPTH];
         end
      end
      e.done = (s == total);
      return e;
   endfunction

   always @(posedge clk) begin
      fire <= run_phase && step;
      hold <= run_phase && !step;
   end

   always @(negedge clk) begin
      if (fire) begin
         if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
         else begin
            last_exp = exp_q.pop_front();
            check("step_output", {done, out_valid, data_out}, last_exp);
         end
      end else if (hold) begin
         check("frozen_output", {done, out_valid, data_out}, {1'b0, last_exp.valid, last_exp.data});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seq(input int passes, input bit gaps);
      start = 1'b1;
      num_passes = PW'(passes);
      tick();
      start = 1'b0;
      check("busy_in_load", busy, 1);
      for (int b = 0; b < DEPTH; b++) begin
         while (gaps && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            data_in = IW'($urandom);
            step = 1'($urandom_range(1, 0));
            tick();
         end
         for (int k = 0; k < LANES; k++) begin
            words[k][b] = DW'($urandom);
            data_in[k*DW +: DW] = words[k][b];
         end
         in_valid = 1'b1;
         step = 1'($urandom_range(1, 0));
         tick();
      end
      in_valid = 1'b0;
      step = 1'b0;
   endtask

   task automatic run_steps(input int passes, input bit toggle, input int limit);
      int tgt, n, total, stop, s, guard;
      tgt = (passes == 0) ? 1 : passes;
      n = DEPTH * tgt;
      total = n + SKEW * (LANES - 1);
      stop = (limit > 0 && limit < total) ? limit : total;
      s = 0;
      guard = 0;
      run_phase = 1'b1;
      while (s < stop && guard < 1000) begin
         step = toggle ? 1'($urandom_range(1, 0)) : 1'b1;
         start = ($urandom_range(3, 0) == 0);
         if (step) begin
            s++;
            exp_q.push_back(model(s, n, total));
         end
         guard++;
         tick();
      end
      if (s < stop) check("run_timeout", s, stop);
      step = 1'b0;
      start = 1'b0;
      run_phase = 1'b0;
   endtask

   task automatic end_checks();
      check("done_pulse", {busy, done}, 2'b11);
      tick();
      check("idle_after_done", {busy, done}, 2'b00);
      check("queue_empty", exp_q.size(), 0);
      tick();
      check("done_single", done, 0);
   endtask

   task automatic check_cleared(input string name);
      check(name, {busy, done, out_valid, data_out}, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p;
      bit g, t;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset_state");
      rst_n = 1'b1;
      tick();

      load_seq(2, 1'b0); run_steps(2, 1'b0, 0); end_checks();
      load_seq(0, 1'b0); run_steps(0, 1'b0, 0); end_checks();
      load_seq(2, 1'b0); run_steps(2, 1'b1, 0); end_checks();
      load_seq(1, 1'b1); run_steps(1, 1'b1, 0); end_checks();
      repeat (3) begin
         p = $urandom_range(3, 0);
         g = 1'($urandom_range(1, 0));
         t = 1'($urandom_range(1, 0));
         load_seq(p, g); run_steps(p, t, 0); end_checks();
      end

      load_seq(2, 1'b1);
      run_steps(2, 1'b0, 3);
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      check_cleared("clear_state");
      last_exp = '0;
      repeat (3) begin
         tick();
         check("no_done_after_clear", {busy, done}, 2'b00);
      end

      load_seq(1, 1'b0);
      run_steps(1, 1'b0, (SKEW == 1) ? DEPTH : DEPTH - 1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_cleared("reset_mid_run");
      tick();
      rst_n = 1'b1;
      last_exp = '0;
      repeat (3) begin
         tick();
         check("no_done_after_reset", {busy, done}, 2'b00);
      end

      load_seq(3, 1'b1); run_steps(3, 1'b1, 0); end_checks();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
